// File: rtl/four004_pkg.sv
// Shared encodings for the 4004 timing and control slice.
// Holds the machine-cycle phase codes, the OPR values that start a
// two-word instruction, the address-nibble select codes and a helper
// that classifies a fetched instruction word.
package four004_pkg;

  // Machine-cycle phases, in execution order.
  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  // OPR values of the instructions that carry a second word.
  localparam logic [3:0] OPR_JCN     = 4'b0001;
  localparam logic [3:0] OPR_FIM_SRC = 4'b0010;
  localparam logic [3:0] OPR_JUN     = 4'b0100;
  localparam logic [3:0] OPR_JMS     = 4'b0101;
  localparam logic [3:0] OPR_ISZ     = 4'b0111;

  // Address nibble select codes driven during A1..A3.
  localparam logic [1:0] NSEL_A1   = 2'd0;
  localparam logic [1:0] NSEL_A2   = 2'd1;
  localparam logic [1:0] NSEL_A3   = 2'd2;
  localparam logic [1:0] NSEL_NONE = 2'd3;

  // True when the word is the first word of a two-word instruction.
  // OPR 0010 is shared by FIM (OPA[0]=0, two words) and SRC (OPA[0]=1).
  function automatic logic is_two_word(input logic [7:0] word);
    logic two_w;
    case (word[7:4])
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two_w = 1'b1;
      OPR_FIM_SRC:                        two_w = ~word[0];
      default:                            two_w = 1'b0;
    endcase
    return two_w;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// 3-bit machine-cycle phase counter.
// Advances A1..X3 and wraps to A1; while in X3 a high hold_i freezes it.
// Ports:
//   clk_i    - system clock, rising edge
//   rst_ni   - asynchronous active-low reset (to A1)
//   hold_i   - stall request, only looked at in X3
//   state_o  - current phase
//   sync_o   - high while in X3
module phase_counter
  import four004_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hold_i,
  output logic [2:0] state_o,
  output logic       sync_o
);

  logic [2:0] state_q;
  logic [2:0] state_d;

  // Next phase: stall only when sitting in X3 with hold asserted.
  always_comb begin
    state_d = state_q;
    if ((state_q == PH_X3) && hold_i) begin
      state_d = state_q;
    end else begin
      state_d = state_q + 3'd1;
    end
  end

  // Phase register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PH_A1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign sync_o  = (state_q == PH_X3);

endmodule

// File: rtl/timing_and_control.sv
// Instruction-cycle timing generator for the 4004 core.
// Steps the 8-phase machine cycle, tracks two-word instructions and
// decodes the per-phase strobes from registered state.
// Ports:
//   clk_1                   - system clock, rising edge
//   reset_n                 - asynchronous active-low reset
//   instruction_decoder     - IR contents, [7:4] OPR, [3:0] OPA
//   hold                    - stall request, honoured in X3 only
//   cycle_state             - current phase (A1=0 .. X3=7)
//   sync                    - high in X3
//   address_drive           - high in A1..A3
//   address_nibble_sel      - 0/1/2 in A1/A2/A3, 3 otherwise
//   pc_increment            - pulse in A3
//   instruction_register_WE - M1/M2 of a first-word cycle
//   operand_WE              - M1/M2 of a second-word cycle
//   execute                 - X1..X3 of a single-word or second-word cycle
//   second_word             - high for the whole second-word cycle
module timing_and_control
  import four004_pkg::*;
(
  input  logic       clk_1,
  input  logic       reset_n,
  input  logic [7:0] instruction_decoder,
  input  logic       hold,
  output logic [2:0] cycle_state,
  output logic       sync,
  output logic       address_drive,
  output logic [1:0] address_nibble_sel,
  output logic       pc_increment,
  output logic       instruction_register_WE,
  output logic       operand_WE,
  output logic       execute,
  output logic       second_word
);

  logic [2:0] state_s;
  logic       sync_s;
  logic       two_word_q, two_word_d;
  logic       second_word_q, second_word_d;
  logic       word_is_two_s;

  phase_counter u_phase_counter (
    .clk_i   (clk_1),
    .rst_ni  (reset_n),
    .hold_i  (hold),
    .state_o (state_s),
    .sync_o  (sync_s)
  );

  assign word_is_two_s = is_two_word(instruction_decoder);

  // Two-word tracking: classify on the edge leaving X1, advance the
  // second-word flag on an unheld X3->A1 transition.
  always_comb begin
    two_word_d    = two_word_q;
    second_word_d = second_word_q;
    if (state_s == PH_X1) begin
      // A second word never starts another second-word cycle.
      two_word_d = word_is_two_s & ~second_word_q;
    end else begin
      two_word_d = two_word_q;
    end
    if ((state_s == PH_X3) && !hold) begin
      second_word_d = two_word_q & ~second_word_q;
    end else begin
      second_word_d = second_word_q;
    end
  end

  // Two-word tracking registers.
  always_ff @(posedge clk_1 or negedge reset_n) begin
    if (!reset_n) begin
      two_word_q    <= 1'b0;
      second_word_q <= 1'b0;
    end else begin
      two_word_q    <= two_word_d;
      second_word_q <= second_word_d;
    end
  end

  // Per-phase strobe decode.
  always_comb begin
    cycle_state             = state_s;
    sync                    = sync_s;
    address_drive           = 1'b0;
    address_nibble_sel      = NSEL_NONE;
    pc_increment            = 1'b0;
    instruction_register_WE = 1'b0;
    operand_WE              = 1'b0;
    execute                 = 1'b0;
    second_word             = second_word_q;
    case (state_s)
      PH_A1: begin
        address_drive      = 1'b1;
        address_nibble_sel = NSEL_A1;
      end
      PH_A2: begin
        address_drive      = 1'b1;
        address_nibble_sel = NSEL_A2;
      end
      PH_A3: begin
        address_drive      = 1'b1;
        address_nibble_sel = NSEL_A3;
        pc_increment       = 1'b1;
      end
      PH_M1, PH_M2: begin
        instruction_register_WE = ~second_word_q;
        operand_WE              = second_word_q;
      end
      PH_X1: begin
        // two_word_q is not yet refreshed in X1, so classify the
        // (already loaded) IR word directly; this keeps the first word
        // of a two-word instruction from ever asserting execute.
        execute = second_word_q | ~word_is_two_s;
      end
      PH_X2, PH_X3: begin
        execute = second_word_q | ~two_word_q;
      end
      default: begin
        address_drive = 1'b0;
      end
    endcase
  end

endmodule
